// File: rtl/ooo_reg_scoreboard.sv
// Per-register busy/tag scoreboard: dispatch marks rd busy with its ROB tag,
// a matching-tag commit clears it, flush drops every in-flight writer.
module ooo_reg_scoreboard #(
   parameter int NUM_REGS = 32,
   parameter int TAG_W    = 4
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic [4:0]       rs1,
   input  logic [4:0]       rs2,
   input  logic [4:0]       rd,
   input  logic             dispatch,
   input  logic             dispatch_wen,
   input  logic [TAG_W-1:0] dispatch_tag,
   input  logic             commit_valid,
   input  logic             commit_wen,
   input  logic [4:0]       commit_rd,
   input  logic [TAG_W-1:0] commit_tag,
   input  logic             flush,
   output logic             rs1_busy,
   output logic             rs2_busy,
   output logic             rd_busy,
   output logic [5:0]       busy_count,
   output logic             all_clear
);

   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busy_next;
   logic [TAG_W-1:0]    tag [NUM_REGS];
   logic                set_en;
   logic                clr_en;
   logic                inc;
   logic                dec;

   assign set_en = dispatch & dispatch_wen & (rd != 5'd0);
   assign clr_en = commit_valid & commit_wen & (commit_rd != 5'd0) &
                   busy[commit_rd] & (tag[commit_rd] == commit_tag);

   // A clear only ever hits a busy entry, so a same-register set+clear nets to zero.
   assign inc = set_en & ~busy[rd];
   assign dec = clr_en & ~(set_en & (rd == commit_rd));

   always_comb begin
      busy_next = busy;
      if (clr_en) busy_next[commit_rd] = 1'b0;
      if (set_en) busy_next[rd] = 1'b1;
      if (flush) busy_next = '0;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         busy       <= '0;
         busy_count <= '0;
         for (int unsigned i = 0; i < NUM_REGS; i++) tag[i] <= '0;
      end else begin
         busy <= busy_next;
         if (flush) begin
            busy_count <= '0;
         end else begin
            busy_count <= busy_count + {5'd0, inc} - {5'd0, dec};
            if (set_en) tag[rd] <= dispatch_tag;
         end
      end
   end

   assign rs1_busy  = busy[rs1];
   assign rs2_busy  = busy[rs2];
   assign rd_busy   = busy[rd];
   assign all_clear = (busy_count == 6'd0);

endmodule
